// File: rtl/modn_pkg.sv
// rtl/modn_pkg.sv - shared FSM state type and default widths for the mod-N sequencer
package modn_pkg;

  localparam int DEF_W  = 4;
  localparam int DEF_RW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/modn_seq_ctrl_if.sv
// rtl/modn_seq_ctrl_if.sv - configuration handshake, run controls and status of the mod-N sequencer
interface modn_seq_ctrl_if import modn_pkg::*; #(
  parameter int W  = DEF_W,
  parameter int RW = DEF_RW
);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [W-1:0]  cfg_mod;
  logic          cfg_dir;
  logic [RW-1:0] cfg_reps;
  logic          pause;
  logic          abort;
  logic [W-1:0]  count;
  logic          wrap;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output cfg_valid, cfg_mod, cfg_dir, cfg_reps, pause, abort,
    input  cfg_ready, count, wrap, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_mod, cfg_dir, cfg_reps, pause, abort,
    output cfg_ready, count, wrap, busy, done, err
  );

endinterface

// File: rtl/modn_core.sv
// rtl/modn_core.sv - W-bit mod-N up/down counter register with wrap-step detect
module modn_core import modn_pkg::*; #(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         dir,
  input  logic [W-1:0] mod,
  output logic [W-1:0] count,
  output logic         wrap_step
);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] top_val;

  assign top_val   = mod - 1'b1;
  assign count     = count_q;
  // A wrap step is a step taken from the last value in the counting direction
  assign wrap_step = step && (dir ? (count_q == top_val) : (count_q == '0));

  // Next count: load wins over step; otherwise hold
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (step) begin
      if (dir) begin
        count_d = (count_q == top_val) ? '0 : count_q + 1'b1;
      end else begin
        count_d = (count_q == '0) ? top_val : count_q - 1'b1;
      end
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/modn_seq_ctrl.sv
// rtl/modn_seq_ctrl.sv - mod-N sequencer: config accept, run/pause/abort FSM, wrap counting
module modn_seq_ctrl import modn_pkg::*; #(
  parameter int W  = DEF_W,
  parameter int RW = DEF_RW
) (
  input  logic           clk,
  input  logic           rst,
  modn_seq_ctrl_if.slave bus
);

  state_e        state_q, state_d;
  logic [W-1:0]  mod_q, mod_d;
  logic          dir_q, dir_d;
  logic [RW-1:0] reps_q, reps_d;
  logic [RW-1:0] wcnt_q, wcnt_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic          load;
  logic [W-1:0]  load_val;
  logic          step;
  logic [W-1:0]  count;
  logic          wrap_step;
  logic [RW-1:0] wcnt_inc;

  assign wcnt_inc = wcnt_q + 1'b1;

  modn_core #(.W(W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .step      (step),
    .dir       (dir_q),
    .mod       (mod_q),
    .count     (count),
    .wrap_step (wrap_step)
  );

  assign bus.cfg_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.count     = count;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;

  // Next state, config latches, wrap count and counter controls; abort outranks pause and stepping
  always_comb begin
    state_d  = state_q;
    mod_d    = mod_q;
    dir_d    = dir_q;
    reps_d   = reps_q;
    wcnt_d   = wcnt_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    step     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          if ((bus.cfg_mod < W'(2)) || (bus.cfg_reps == '0)) begin
            err_d = 1'b1;
          end else begin
            mod_d    = bus.cfg_mod;
            dir_d    = bus.cfg_dir;
            reps_d   = bus.cfg_reps;
            wcnt_d   = '0;
            load     = 1'b1;
            load_val = bus.cfg_dir ? '0 : bus.cfg_mod - 1'b1;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.pause) begin
          state_d = ST_PAUSE;
        end else begin
          step = 1'b1;
          if (wrap_step) begin
            wrap_d = 1'b1;
            wcnt_d = wcnt_inc;
            if (wcnt_inc == reps_q) state_d = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.abort) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end else if (!bus.pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, configuration and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mod_q   <= '0;
      dir_q   <= 1'b0;
      reps_q  <= '0;
      wcnt_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      dir_q   <= dir_d;
      reps_q  <= reps_d;
      wcnt_q  <= wcnt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_modn_seq_ctrl.sv
// tb/tb_modn_seq_ctrl.sv - scoreboard bench for the mod-N sequencer
module tb_modn_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [8:0] q[$];
  logic [8:0] exp_v;

  modn_seq_ctrl_if #(.W(4), .RW(4)) bus ();

  modn_seq_ctrl #(.W(4), .RW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // packed {count, wrap, busy, done, err, ready}
  function automatic logic [8:0] pk(input int c, input bit wr, input bit bu,
                                    input bit dn, input bit er, input bit rd);
    logic [3:0] c4;
    c4 = c[3:0];
    return {c4, wr, bu, dn, er, rd};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.count, bus.wrap, bus.busy, bus.done, bus.err, bus.cfg_ready};
  endfunction

  task automatic drive(input bit v, input int m, input bit d, input int r,
                       input bit p, input bit a);
    logic [3:0] m4;
    logic [3:0] r4;
    m4 = m[3:0];
    r4 = r[3:0];
    bus.cfg_valid = v;
    bus.cfg_mod   = m4;
    bus.cfg_dir   = d;
    bus.cfg_reps  = r4;
    bus.pause     = p;
    bus.abort     = a;
  endtask

  task automatic test_reset();
    q.delete();
    q.push_back(pk(0, 0, 0, 0, 0, 1));
    q.push_back(pk(0, 0, 0, 0, 0, 1));
    for (int c = 0; c < 2; c++) begin
      rst = (c == 0);
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      exp_v = q.pop_front(); vectors++;
      if (obs() !== exp_v) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %h want %h", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_up();
    q.delete();
    q.push_back(pk(0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 9; k++) q.push_back(pk(k % 5, (k % 5) == 0, 1, 0, 0, 0));
    q.push_back(pk(0, 1, 0, 1, 0, 0));
    q.push_back(pk(0, 0, 0, 0, 0, 1));
    for (int c = 0; c < 12; c++) begin
      drive(c == 0, 5, 1, 2, 0, 0);
      @(posedge clk); #1;
      exp_v = q.pop_front(); vectors++;
      if (obs() !== exp_v) begin
        miscompares++;
        $display("FAIL up_mod5_reps2 cyc %0d: got %h want %h", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_down();
    q.delete();
    q.push_back(pk(2, 0, 1, 0, 0, 0));
    q.push_back(pk(1, 0, 1, 0, 0, 0));
    q.push_back(pk(0, 0, 1, 0, 0, 0));
    q.push_back(pk(2, 1, 0, 1, 0, 0));
    q.push_back(pk(2, 0, 0, 0, 0, 1));
    for (int c = 0; c < 5; c++) begin
      // a bad config is held on cfg_valid while busy and must be ignored
      if (c == 0)      drive(1, 3, 0, 1, 0, 0);
      else if (c < 4)  drive(1, 1, 0, 0, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      exp_v = q.pop_front(); vectors++;
      if (obs() !== exp_v) begin
        miscompares++;
        $display("FAIL down_mod3 cyc %0d: got %h want %h", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_reject();
    q.delete();
    q.push_back(pk(2, 0, 0, 0, 1, 1));
    q.push_back(pk(2, 0, 0, 0, 0, 1));
    q.push_back(pk(2, 0, 0, 0, 1, 1));
    q.push_back(pk(2, 0, 0, 0, 0, 1));
    for (int c = 0; c < 4; c++) begin
      if (c == 0)      drive(1, 1, 1, 3, 0, 0);
      else if (c == 2) drive(1, 5, 1, 0, 0, 0);
      else             drive(0, 5, 1, 2, 0, 0);
      @(posedge clk); #1;
      exp_v = q.pop_front(); vectors++;
      if (obs() !== exp_v) begin
        miscompares++;
        $display("FAIL reject cyc %0d: got %h want %h", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_pause();
    q.delete();
    q.push_back(pk(0, 0, 1, 0, 0, 0));
    q.push_back(pk(1, 0, 1, 0, 0, 0));
    q.push_back(pk(2, 0, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++) q.push_back(pk(2, 0, 1, 0, 0, 0));
    q.push_back(pk(3, 0, 1, 0, 0, 0));
    q.push_back(pk(4, 0, 1, 0, 0, 0));
    q.push_back(pk(0, 1, 0, 1, 0, 0));
    q.push_back(pk(0, 0, 0, 0, 0, 1));
    for (int c = 0; c < 11; c++) begin
      drive(c == 0, 5, 1, 1, (c >= 3 && c <= 5), 0);
      @(posedge clk); #1;
      exp_v = q.pop_front(); vectors++;
      if (obs() !== exp_v) begin
        miscompares++;
        $display("FAIL pause cyc %0d: got %h want %h", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_abort();
    q.delete();
    // abort while paused
    q.push_back(pk(0, 0, 1, 0, 0, 0));
    q.push_back(pk(1, 0, 1, 0, 0, 0));
    q.push_back(pk(1, 0, 1, 0, 0, 0));
    q.push_back(pk(0, 0, 0, 0, 0, 1));
    q.push_back(pk(0, 0, 0, 0, 0, 1));
    // abort on the completing wrap step of a down run
    q.push_back(pk(2, 0, 1, 0, 0, 0));
    q.push_back(pk(1, 0, 1, 0, 0, 0));
    q.push_back(pk(0, 0, 1, 0, 0, 0));
    q.push_back(pk(0, 0, 0, 0, 0, 1));
    q.push_back(pk(0, 0, 0, 0, 0, 1));
    for (int c = 0; c < 10; c++) begin
      if (c < 5) drive(c == 0, 5, 1, 2, (c == 2 || c == 3), c == 3);
      else       drive(c == 5, 3, 0, 1, 0, c == 8);
      @(posedge clk); #1;
      exp_v = q.pop_front(); vectors++;
      if (obs() !== exp_v) begin
        miscompares++;
        $display("FAIL abort cyc %0d: got %h want %h", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_rst_midrun();
    q.delete();
    for (int k = 0; k < 4; k++) q.push_back(pk(k, 0, 1, 0, 0, 0));
    q.push_back(pk(0, 0, 0, 0, 0, 1));
    q.push_back(pk(3, 0, 1, 0, 0, 0));
    q.push_back(pk(2, 0, 1, 0, 0, 0));
    q.push_back(pk(1, 0, 1, 0, 0, 0));
    q.push_back(pk(0, 0, 1, 0, 0, 0));
    q.push_back(pk(3, 1, 0, 1, 0, 0));
    q.push_back(pk(3, 0, 0, 0, 0, 1));
    for (int c = 0; c < 11; c++) begin
      rst = (c == 4);
      if (c == 0)      drive(1, 5, 1, 2, 0, 0);
      else if (c == 5) drive(1, 4, 0, 1, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      exp_v = q.pop_front(); vectors++;
      if (obs() !== exp_v) begin
        miscompares++;
        $display("FAIL rst_midrun cyc %0d: got %h want %h", c, obs(), exp_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_up();
    test_down();
    test_reject();
    test_pause();
    test_abort();
    test_rst_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modn_seq_ctrl.md
MODN_SEQ_CTRL -- requirements
Module: modn_seq_ctrl

Interface
REQ-001 Parameter W, default 4: counter and modulus width in bits.
REQ-002 Parameter RW, default 4: repeat-count width in bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_valid  input  1  configuration offered.
REQ-006 cfg_ready  output  1  controller accepts a configuration this cycle.
REQ-007 cfg_mod  input  W  modulus N for the run.
REQ-008 cfg_dir  input  1  1 = up-count, 0 = down-count.
REQ-009 cfg_reps  input  RW  number of full wraps to run.
REQ-010 pause  input  1  level; holds the count while high.
REQ-011 abort  input  1  level; terminates the run.
REQ-012 count  output  W  current counter value.
REQ-013 wrap  output  1  one-cycle pulse on each wrap-around step.
REQ-014 busy  output  1  high in RUN or PAUSE.
REQ-015 done  output  1  one-cycle pulse when the programmed wraps complete.
REQ-016 err  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-018 cfg_ready SHALL be 1 only in IDLE; cfg_valid in any other state SHALL be ignored.
REQ-019 Accept condition: IDLE with cfg_valid=1. If cfg_mod<2 or cfg_reps=0, err SHALL pulse on the next cycle and the FSM SHALL stay in IDLE with count unchanged.
REQ-020 On a valid accept, the controller SHALL latch mod, dir and reps, load count with 0 (up) or mod-1 (down), clear the wrap counter, and enter RUN at the same edge.
REQ-021 In RUN with pause=0 and abort=0, each edge SHALL step count: up from mod-1 to 0, otherwise +1; down from 0 to mod-1, otherwise -1.
REQ-022 wrap SHALL be high for the cycle following each wrap-around step.
REQ-023 On the wrap step that makes the wrap total equal to reps, the FSM SHALL enter DONE. A run therefore takes exactly reps*mod steps.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, count SHALL hold, and the FSM SHALL return to IDLE on the next edge.
REQ-025 pause=1 in RUN SHALL enter PAUSE without stepping. pause=0 in PAUSE SHALL return to RUN without stepping; stepping resumes on the following edge.
REQ-026 abort=1 in RUN or PAUSE SHALL force IDLE and count=0, with no done or wrap pulse. abort SHALL take priority over pause and over a completing step.
REQ-027 Arithmetic SHALL be W-bit unsigned. count SHALL never leave the range 0..mod-1 during a run. The wrap counter SHALL be RW bits.
REQ-028 count SHALL hold its value in IDLE.

Reset
REQ-029 rst=1 SHALL force, at the next edge: state IDLE, count=0, wrap counter=0, latched configuration=0, and wrap/done/err/busy=0.
REQ-030 rst SHALL take priority over all inputs, including during RUN or PAUSE. The aborted run SHALL produce no done.
REQ-031 After rst deasserts, cfg_ready SHALL be 1.

Structure
REQ-032 A shared package modn_pkg SHALL hold the FSM state enum and the default W and RW constants.
REQ-033 The counter register SHALL be a sub-module modn_core with inputs load, load_val, step, dir and mod, and outputs count and wrap_step. modn_seq_ctrl SHALL contain the FSM, configuration latches and wrap counter.

Verification
REQ-034 mod=5, dir=1, reps=2 -> count 0,1,2,3,4,0,1,2,3,4,0; wrap after each 4->0; done 1 cycle after the 10th step; busy falls.
REQ-035 mod=3, dir=0, reps=1 -> count 2,1,0,2; one wrap; then done.
REQ-036 cfg_mod=1, or cfg_reps=0 -> err pulses once, FSM stays IDLE, busy stays 0, count unchanged.
REQ-037 mod=5, up; pause for 3 cycles at count=2 -> count holds 2 for those cycles plus 1 resume cycle, then 3,4,0; total steps unchanged.
REQ-038 abort asserted in PAUSE, and separately on the completing wrap step -> IDLE, count=0, no done, no wrap.
REQ-039 rst asserted mid-RUN at count=3 -> next cycle count=0, busy=0, cfg_ready=1; a new configuration is accepted normally.
